// File: rtl/an_sec_decoder_seq.sv
// an_sec_decoder_seq
//   Sequential single-error-correcting decoder for AN arithmetic codes.
//   A codeword W = A*N + e, with e = +/-2^pos, is divided by A with a
//   restoring divider (one quotient bit per cycle). A non-zero residue is
//   then matched against +/-2^i mod A for i = 0..W_BITS-1, while tracking
//   floor(2^i / A) so the correction needs no second division.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready/in_w  : codeword input handshake (ready only when idle)
//   out_valid/out_ready     : result handshake (valid held until accepted)
//   out_n                   : decoded value N
//   out_corr / out_unc      : single error corrected / error uncorrectable
//   out_sign / out_pos      : corrected error was -2^pos (1) or +2^pos (0)
module an_sec_decoder_seq #(
  parameter int A      = 83,
  parameter int A_BITS = 7,
  parameter int N_BITS = 31,
  parameter int W_BITS = 38
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W_BITS-1:0]         in_w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_BITS-1:0]         out_n,
  output logic                      out_corr,
  output logic                      out_unc,
  output logic                      out_sign,
  output logic [$clog2(W_BITS)-1:0] out_pos
);

  localparam int POS_W = $clog2(W_BITS);
  localparam logic [POS_W-1:0]  LAST  = POS_W'(W_BITS - 1);
  localparam logic [A_BITS:0]   A_EXT = (A_BITS + 1)'(A);
  localparam logic [A_BITS-1:0] A_R   = A_BITS'(A);

  typedef enum logic [2:0] {IDLE, DIV, SEARCH, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [W_BITS-1:0] q_r;     // dividend shifting out / quotient shifting in
  logic [A_BITS-1:0] r_r;     // partial remainder, final residue
  logic [POS_W-1:0]  i_r;     // DIV bit counter, then SEARCH position
  logic [A_BITS-1:0] p_r;     // 2^i mod A
  logic [W_BITS-1:0] k_r;     // floor(2^i / A)
  logic              sign_r;
  logic [POS_W-1:0]  pos_r;

  // Corrected value must lie in [0, 2^N_BITS).
  function automatic logic n_in_range(input logic signed [W_BITS:0] v);
    return !v[W_BITS] && (v[W_BITS-1:N_BITS] == '0);
  endfunction

  logic [A_BITS:0]        trial, rem_full, p2, p_full;
  logic                   div_ge, p_ge, div_last, i_last, match_pos, match_neg;
  logic [A_BITS-1:0]      rem_nxt, p_nxt;
  logic [W_BITS-1:0]      k_nxt, q_fin;
  logic signed [W_BITS:0] q_s, k_s, fix_n;

  always_comb begin
    trial     = {r_r, q_r[W_BITS-1]};
    div_ge    = (trial >= A_EXT);
    rem_full  = div_ge ? (trial - A_EXT) : trial;
    rem_nxt   = rem_full[A_BITS-1:0];
    q_fin     = {q_r[W_BITS-2:0], div_ge};
    div_last  = (i_r == LAST);
    i_last    = (i_r == LAST);
    // Positive match is tested first so it wins when both hold.
    match_pos = (r_r == p_r);
    match_neg = (r_r == (A_R - p_r));
    p2        = {p_r, 1'b0};
    p_ge      = (p2 >= A_EXT);
    p_full    = p_ge ? (p2 - A_EXT) : p2;
    p_nxt     = p_full[A_BITS-1:0];
    k_nxt     = {k_r[W_BITS-2:0], 1'b0} + W_BITS'(p_ge);
    q_s       = signed'({1'b0, q_r});
    k_s       = signed'({1'b0, k_r});
    // W = A*Q + r with r = +2^i mod A gives N = Q - k; with r = A - (2^i mod A)
    // the codeword is A*N - 2^i, so N = Q + k + 1.
    fix_n     = sign_r ? (q_s + k_s + (W_BITS + 1)'(1)) : (q_s - k_s);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DIV;
      DIV:     if (div_last) state_nxt = (rem_nxt == '0) ? DONE : SEARCH;
      SEARCH:  begin
        if (match_pos || match_neg) state_nxt = FIX;
        else if (i_last)            state_nxt = DONE;
      end
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0; r_r <= '0; i_r <= '0; p_r <= '0; k_r <= '0;
      sign_r <= 1'b0; pos_r <= '0;
      out_n <= '0; out_corr <= 1'b0; out_unc <= 1'b0;
      out_sign <= 1'b0; out_pos <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          q_r <= in_w;
          r_r <= '0;
          i_r <= '0;
        end
        DIV: begin
          q_r <= q_fin;
          r_r <= rem_nxt;
          i_r <= i_r + 1'b1;
          if (div_last) begin
            i_r <= '0;
            p_r <= A_BITS'(1);
            k_r <= '0;
            if (rem_nxt == '0) begin
              out_n    <= q_fin[N_BITS-1:0];
              out_corr <= 1'b0;
              out_unc  <= 1'b0;
              out_sign <= 1'b0;
              out_pos  <= '0;
            end
          end
        end
        SEARCH: begin
          if (match_pos) begin
            sign_r <= 1'b0;
            pos_r  <= i_r;
          end else if (match_neg) begin
            sign_r <= 1'b1;
            pos_r  <= i_r;
          end else begin
            p_r <= p_nxt;
            k_r <= k_nxt;
            i_r <= i_r + 1'b1;
            if (i_last) begin
              out_n    <= q_r[N_BITS-1:0];
              out_corr <= 1'b0;
              out_unc  <= 1'b1;
              out_sign <= 1'b0;
              out_pos  <= '0;
            end
          end
        end
        FIX: begin
          if (n_in_range(fix_n)) begin
            out_n    <= fix_n[N_BITS-1:0];
            out_corr <= 1'b1;
            out_unc  <= 1'b0;
            out_sign <= sign_r;
            out_pos  <= pos_r;
          end else begin
            out_n    <= q_r[N_BITS-1:0];
            out_corr <= 1'b0;
            out_unc  <= 1'b1;
            out_sign <= 1'b0;
            out_pos  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
module tb_an_sec_decoder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [37:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_n;
  logic        out_corr;
  logic        out_unc;
  logic        out_sign;
  logic [5:0]  out_pos;

  an_sec_decoder_seq #(.A(83), .A_BITS(7), .N_BITS(31), .W_BITS(38)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_n(out_n), .out_corr(out_corr), .out_unc(out_unc),
    .out_sign(out_sign), .out_pos(out_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [37:0] w;
    logic [30:0] n;
    logic        corr;
    logic        unc;
    logic        sign;
    logic [5:0]  pos;
    int          t;     // cycle of first out_valid, accept cycle = 0
  } vec_t;

  vec_t tbl[11];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one codeword, then wait for and score its result. The result is
  // held for 'hold' cycles of back-pressure before being accepted.
  task automatic run_one(input vec_t v, input int hold);
    vec_t e;
    int   edges;
    int   guard;
    exp_q.push_back(v);
    @(negedge clk);
    in_w     = v.w;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_w     = {$urandom, $urandom};   // must not disturb the decode
    chk("busy_in_ready", in_ready, 0);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!out_valid && edges < 200);
    e = exp_q.pop_front();
    if (!out_valid) begin
      chk("timeout_out_valid", out_valid, 1);
      return;
    end
    chk("latency", edges + 1, e.t);
    chk("out_n", out_n, e.n);
    chk("out_corr", out_corr, e.corr);
    chk("out_unc", out_unc, e.unc);
    chk("out_sign", out_sign, e.sign);
    chk("out_pos", out_pos, e.pos);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_n", out_n, e.n);
      chk("hold_flags", {out_corr, out_unc, out_sign, out_pos}, {e.corr, e.unc, e.sign, e.pos});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    tbl[0]  = '{38'd83000,        31'd1000,       1'b0, 1'b0, 1'b0, 6'd0, 39};
    tbl[1]  = '{38'd83001,        31'd1000,       1'b1, 1'b0, 1'b0, 6'd0, 41};
    tbl[2]  = '{38'd82996,        31'd1000,       1'b1, 1'b0, 1'b1, 6'd2, 43};
    tbl[3]  = '{38'd83128,        31'd1000,       1'b1, 1'b0, 1'b0, 6'd7, 48};
    tbl[4]  = '{38'd83031,        31'd1000,       1'b0, 1'b1, 1'b0, 6'd0, 77};
    tbl[5]  = '{38'd0,            31'd0,          1'b0, 1'b0, 1'b0, 6'd0, 39};
    tbl[6]  = '{38'd417,          31'd5,          1'b1, 1'b0, 1'b0, 6'd1, 42};
    tbl[7]  = '{38'd868,          31'd12,         1'b1, 1'b0, 1'b1, 6'd7, 48};
    // Q=0, r=45 matches +2^7 with k=1: N=-1 is out of range.
    tbl[8]  = '{38'd45,           31'd0,          1'b0, 1'b1, 1'b0, 6'd0, 48};
    // Q=2^31-1, r=82 matches -2^0: N=2^31 is out of range.
    tbl[9]  = '{38'd178241142783, 31'h7FFFFFFF,   1'b0, 1'b1, 1'b0, 6'd0, 41};
    // Q=2^31-1, r=1 matches +2^0: N=Q, largest in-range value.
    tbl[10] = '{38'd178241142702, 31'h7FFFFFFF,   1'b1, 1'b0, 1'b0, 6'd0, 41};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_w      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", {out_n, out_corr, out_unc, out_sign, out_pos}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) run_one(tbl[v], 0);

    // Back-pressure: result must hold for 10 cycles.
    run_one(tbl[3], 10);

    // Reset in the middle of SEARCH abandons the codeword.
    @(negedge clk);
    in_w     = 38'd83031;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_search_valid", out_valid, 0);
    chk("rst_search_ready", in_ready, 1);
    chk("rst_search_outputs", {out_n, out_corr, out_unc, out_sign, out_pos}, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_result", out_valid, 0);
    run_one(tbl[1], 0);

    // Reset takes priority over a simultaneous output handshake.
    @(negedge clk);
    in_w     = 38'd83000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("rst_hs_outputs", {out_valid, out_n, out_corr, out_unc}, 0);
    chk("rst_hs_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
